ifetch_unit: RTL



---
 rtl/ifetch_unit.sv | 73 +++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: owns the PC, reads imem combinationally and
// registers each fetched word into a valid/ready stage toward decode.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               run,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_pc4,
    output logic [COUNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic        load;
    logic        accept;

    assign imem_addr = pc;
    assign accept    = out_valid && out_ready;
    assign load      = (state == RUN) && run && (!out_valid || out_ready) && !redirect_valid;

    // A redirect freezes the RUN/HOLD decision for that cycle; BOOT always leaves.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (!redirect_valid && !run) state_nxt = HOLD;
            HOLD:    if (!redirect_valid && run)  state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_pc      <= 32'h0;
            out_pc4     <= 32'h4;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            // A handshake in a redirect cycle still counts before the flush.
            if (accept)
                fetch_count <= fetch_count + COUNT_W'(1);
            if (redirect_valid) begin
                pc        <= {redirect_pc[31:2], 2'b00};
                out_valid <= 1'b0;
            end else if (load) begin
                pc        <= pc + 32'd4;
                out_instr <= imem_rdata;
                out_pc    <= pc;
                out_pc4   <= pc + 32'd4;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
